// File: rtl/cc_bcd2bin_seq_if.sv
// Handshake and data bundle for the sequential BCD-to-binary converter.
interface cc_bcd2bin_seq_if #(
  parameter int unsigned NDIGITS  = 3,
  parameter int unsigned BINWIDTH = 10
);
  logic                    CC_BCD2BIN_start_In;
  logic [4*NDIGITS-1:0]    CC_BCD2BIN_bcd_InBUS;
  logic [BINWIDTH-1:0]     CC_BCD2BIN_bin_OutBUS;
  logic                    CC_BCD2BIN_busy_Out;
  logic                    CC_BCD2BIN_done_Out;
  logic                    CC_BCD2BIN_error_Out;

  modport master (
    output CC_BCD2BIN_start_In,
    output CC_BCD2BIN_bcd_InBUS,
    input  CC_BCD2BIN_bin_OutBUS,
    input  CC_BCD2BIN_busy_Out,
    input  CC_BCD2BIN_done_Out,
    input  CC_BCD2BIN_error_Out
  );

  modport slave (
    input  CC_BCD2BIN_start_In,
    input  CC_BCD2BIN_bcd_InBUS,
    output CC_BCD2BIN_bin_OutBUS,
    output CC_BCD2BIN_busy_Out,
    output CC_BCD2BIN_done_Out,
    output CC_BCD2BIN_error_Out
  );
endinterface

// File: rtl/cc_bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double dabble:
// one right shift plus per-digit subtract-3 correction per clock.
module cc_bcd2bin_seq #(
  parameter int unsigned NDIGITS  = 3,
  parameter int unsigned BINWIDTH = 10
) (
  input  logic                  CC_BCD2BIN_CLOCK_50,
  input  logic                  CC_BCD2BIN_RESET_InHigh,
  cc_bcd2bin_seq_if.slave       bcd_if
);

  localparam int unsigned BCDW = 4 * NDIGITS;
  localparam int unsigned SW   = BCDW + BINWIDTH;
  localparam int unsigned CW   = (BINWIDTH > 1) ? $clog2(BINWIDTH + 1) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       scratch_q, scratch_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BINWIDTH-1:0] bin_q, bin_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic [SW-1:0]       shifted_c;
  logic [SW-1:0]       corrected_c;
  logic                digits_ok_c;

  // Register bank; reset aborts any conversion without a done pulse.
  always_ff @(posedge CC_BCD2BIN_CLOCK_50) begin
    if (CC_BCD2BIN_RESET_InHigh) begin
      state_q   <= S_IDLE;
      scratch_q <= '0;
      cnt_q     <= '0;
      bin_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Next-state, datapath step and output updates.
  always_comb begin
    state_d     = state_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    digits_ok_c = 1'b1;

    shifted_c   = scratch_q >> 1;
    corrected_c = shifted_c;
    // Digits are independent 4-bit fields; no borrow crosses between them.
    for (int i = 0; i < int'(NDIGITS); i++) begin
      if (shifted_c[BINWIDTH + 4*i + 3]) begin
        corrected_c[BINWIDTH + 4*i +: 4] = shifted_c[BINWIDTH + 4*i +: 4] - 4'd3;
      end
    end

    for (int i = 0; i < int'(NDIGITS); i++) begin
      if (bcd_if.CC_BCD2BIN_bcd_InBUS[4*i +: 4] > 4'd9) begin
        digits_ok_c = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bcd_if.CC_BCD2BIN_start_In) begin
          if (!digits_ok_c) begin
            error_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            scratch_d = {bcd_if.CC_BCD2BIN_bcd_InBUS, {BINWIDTH{1'b0}}};
            cnt_d     = '0;
            error_d   = 1'b0;
            busy_d    = 1'b1;
            state_d   = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        scratch_d = corrected_c;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(BINWIDTH - 1)) begin
          bin_d   = corrected_c[BINWIDTH-1:0];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bcd_if.CC_BCD2BIN_bin_OutBUS = bin_q;
  assign bcd_if.CC_BCD2BIN_busy_Out   = busy_q;
  assign bcd_if.CC_BCD2BIN_done_Out   = done_q;
  assign bcd_if.CC_BCD2BIN_error_Out  = error_q;

endmodule

// File: tb/tb_cc_bcd2bin_seq.sv
// Directed self-checking bench for cc_bcd2bin_seq (3 digits, 10-bit result).
module tb_cc_bcd2bin_seq;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  cc_bcd2bin_seq_if #(.NDIGITS(3), .BINWIDTH(10)) bif ();

  cc_bcd2bin_seq #(.NDIGITS(3), .BINWIDTH(10)) dut (
    .CC_BCD2BIN_CLOCK_50     (clk),
    .CC_BCD2BIN_RESET_InHigh (rst),
    .bcd_if                  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; drive and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_conv(input logic [11:0] bcd, input logic [9:0] exp, input string tag);
    int n;
    bif.CC_BCD2BIN_bcd_InBUS = bcd;
    bif.CC_BCD2BIN_start_In  = 1'b1;
    tick();
    bif.CC_BCD2BIN_start_In  = 1'b0;
    chk({tag, "_busy"}, 32'(bif.CC_BCD2BIN_busy_Out), 32'd1);
    n = 0;
    while (!bif.CC_BCD2BIN_done_Out && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd10);
    chk({tag, "_bin"}, 32'(bif.CC_BCD2BIN_bin_OutBUS), 32'(exp));
    chk({tag, "_err"}, 32'(bif.CC_BCD2BIN_error_Out), 32'd0);
    chk({tag, "_idle"}, 32'(bif.CC_BCD2BIN_busy_Out), 32'd0);
  endtask

  initial begin
    int n;
    logic [11:0] sweep_bcd;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bif.CC_BCD2BIN_start_In  = 1'b0;
    bif.CC_BCD2BIN_bcd_InBUS = 12'h000;
    #1;
    tick();
    tick();
    chk("rst_bin",   32'(bif.CC_BCD2BIN_bin_OutBUS), 32'd0);
    chk("rst_busy",  32'(bif.CC_BCD2BIN_busy_Out),   32'd0);
    chk("rst_done",  32'(bif.CC_BCD2BIN_done_Out),   32'd0);
    chk("rst_error", 32'(bif.CC_BCD2BIN_error_Out),  32'd0);
    rst = 1'b0;
    tick();

    // Basic conversions with hand-computed results.
    run_conv(12'h999, 10'd999, "c999");
    tick();
    chk("c999_done_drop", 32'(bif.CC_BCD2BIN_done_Out), 32'd0);
    run_conv(12'h000, 10'd0,   "c000");
    run_conv(12'h255, 10'd255, "c255");
    run_conv(12'h100, 10'd100, "c100");
    run_conv(12'h009, 10'd9,   "c009");
    tick();

    // Invalid digit: immediate done+error, result retained, never busy.
    bif.CC_BCD2BIN_bcd_InBUS = 12'h1A5;
    bif.CC_BCD2BIN_start_In  = 1'b1;
    tick();
    bif.CC_BCD2BIN_start_In  = 1'b0;
    chk("bad_done",  32'(bif.CC_BCD2BIN_done_Out),   32'd1);
    chk("bad_error", 32'(bif.CC_BCD2BIN_error_Out),  32'd1);
    chk("bad_busy",  32'(bif.CC_BCD2BIN_busy_Out),   32'd0);
    chk("bad_bin",   32'(bif.CC_BCD2BIN_bin_OutBUS), 32'd9);
    tick();
    chk("bad_done_drop", 32'(bif.CC_BCD2BIN_done_Out),  32'd0);
    chk("bad_err_hold",  32'(bif.CC_BCD2BIN_error_Out), 32'd1);
    chk("bad_busy2",     32'(bif.CC_BCD2BIN_busy_Out),  32'd0);
    run_conv(12'h042, 10'd42, "c042");
    tick();

    // Start during SHIFT ignored; back-to-back start in the done cycle accepted.
    bif.CC_BCD2BIN_bcd_InBUS = 12'h123;
    bif.CC_BCD2BIN_start_In  = 1'b1;
    tick();
    bif.CC_BCD2BIN_start_In  = 1'b0;
    n = 0;
    tick(); n++;
    tick(); n++;
    bif.CC_BCD2BIN_bcd_InBUS = 12'h456;
    bif.CC_BCD2BIN_start_In  = 1'b1;
    tick(); n++;
    bif.CC_BCD2BIN_start_In  = 1'b0;
    chk("ign_busy", 32'(bif.CC_BCD2BIN_busy_Out), 32'd1);
    while (!bif.CC_BCD2BIN_done_Out && n < 30) begin
      tick();
      n++;
    end
    chk("ign_lat", 32'(n), 32'd10);
    chk("ign_bin", 32'(bif.CC_BCD2BIN_bin_OutBUS), 32'd123);
    run_conv(12'h456, 10'd456, "b2b");
    tick();
    chk("b2b_done_drop", 32'(bif.CC_BCD2BIN_done_Out), 32'd0);

    // Reset in the middle of a conversion aborts it silently.
    bif.CC_BCD2BIN_bcd_InBUS = 12'h777;
    bif.CC_BCD2BIN_start_In  = 1'b1;
    tick();
    bif.CC_BCD2BIN_start_In  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_bin",  32'(bif.CC_BCD2BIN_bin_OutBUS), 32'd0);
    chk("abort_busy", 32'(bif.CC_BCD2BIN_busy_Out),   32'd0);
    chk("abort_done", 32'(bif.CC_BCD2BIN_done_Out),   32'd0);
    chk("abort_err",  32'(bif.CC_BCD2BIN_error_Out),  32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("abort_quiet", 32'({bif.CC_BCD2BIN_done_Out, bif.CC_BCD2BIN_busy_Out}), 32'd0);
    end
    run_conv(12'h777, 10'd777, "c777");
    tick();

    // Input bus churn after the accepting edge must not disturb the result.
    bif.CC_BCD2BIN_bcd_InBUS = 12'h500;
    bif.CC_BCD2BIN_start_In  = 1'b1;
    tick();
    bif.CC_BCD2BIN_start_In  = 1'b0;
    n = 0;
    while (!bif.CC_BCD2BIN_done_Out && n < 30) begin
      bif.CC_BCD2BIN_bcd_InBUS = 12'($urandom);
      tick();
      n++;
    end
    chk("churn_lat", 32'(n), 32'd10);
    chk("churn_bin", 32'(bif.CC_BCD2BIN_bin_OutBUS), 32'd500);
    tick();

    // Full sweep against an integer decimal model.
    for (int v = 0; v < 1000; v++) begin
      sweep_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      run_conv(sweep_bcd, 10'(v), "sweep");
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
